load_store_unit: RTL
====================

# load_store_unit

Sits between the CPU memory pipeline stage and the word-addressed data memory. Accepts one load/store request at a time over a valid/ready handshake and translates byte addresses to word indices. Performs read-modify-write for byte and halfword stores, and sign/zero-extends load results. Returns each result over a valid/ready response handshake and flags misaligned or out-of-range accesses without touching memory.

## Interface
- ADDR_W, 16: width of the memory word index; legal byte addresses are 0 .. 2^(ADDR_W+2)-1.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; equals (state == IDLE).
- req_op  in  3  0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU, 5=SW, 6=SH, 7=SB.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; SH uses [15:0], SB uses [7:0].
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_data  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned or out-of-range request.
- mem_addr  out  ADDR_W  word index to data memory, = addr_q[ADDR_W+1:2].
- mem_we  out  1  write enable to data memory.
- mem_wdata  out  32  write word to data memory.
- mem_rdata  in  32  combinational read word from data memory at mem_addr.

## Operation
- Request registers op_q, addr_q, wdata_q load on handshake (req_valid && req_ready).
- Error check at accept:
  - LW/SW with addr[1:0] != 0 is an error.
  - LH/LHU/SH with addr[0] != 0 is an error.
  - Any op with addr[31:ADDR_W+2] != 0 is an error.
- Lane mapping is little-endian: byte k = bits [8k+7:8k] for addr[1:0] = k; halfword h = bits [16h+15:16h] for addr[1] = h.
- States and transitions:
  - IDLE: on accept, go to ERR if the request is an error, else ACCESS.
  - ACCESS, loads: extract the lane from mem_rdata, extend it (LH/LB sign-extend, LHU/LBU zero-extend, LW as-is), register it into resp_data, then go to RESP.
  - ACCESS, SW: mem_we=1, mem_wdata=wdata_q, then go to RESP.
  - ACCESS, SH/SB: mem_we=0; merge the store lane into mem_rdata, register it as merge_q, then go to WRITE.
  - WRITE: mem_we=1, mem_wdata=merge_q (other lanes preserved), then go to RESP.
  - ERR: set resp_err=1, resp_data=0, then go to RESP. No memory access occurs.
  - RESP: resp_valid=1. Go to IDLE when resp_ready=1.
- mem_we is decoded from state only; it is never asserted in IDLE, ERR or RESP.
- mem_addr is driven from addr_q in every state.
- resp_data and resp_err hold stable while resp_valid=1, and clear to 0 on the cycle after the response handshake.

## Timing
- Reset (async, immediate): state=IDLE, resp_valid=0, resp_data=0, resp_err=0, mem_we=0, all request registers 0.
  - req_ready=1 while in IDLE, including during reset.
- Latency from the accept edge to the first resp_valid cycle:
  - LW/LH/LHU/LB/LBU/SW: 2 cycles.
  - SH/SB: 3 cycles.
  - Errors: 2 cycles.
- Memory write commits on the rising edge that ends ACCESS (SW) or WRITE (SH/SB).
- Back-to-back operation:
  - The next request is accepted on the cycle after the response handshake, because IDLE is re-entered there.
  - Peak throughput is one LW per 3 cycles when resp_ready is held high.
- Stalling: resp_ready=0 holds RESP indefinitely; req_ready stays 0 throughout.
- Reset mid-operation:
  - Reset in ACCESS of SH/SB leaves memory unmodified.
  - Reset in WRITE drops mem_we immediately. Whether that write commits depends on the edge position, and this is not checked.
  - A response in progress is discarded.
- req_valid while not ready is ignored; the unit never samples req_* outside IDLE.

## Test plan
- Memory preloaded with word i = i. LW addr 0x14 -> resp_data 0x00000005, err 0, resp_valid 2 cycles after accept, mem_we never high.
- Store word 7 = 0x80FF7F01. Then:
  - LB 0x1D -> 0x0000007F.
  - LB 0x1E -> 0xFFFFFFFF.
  - LBU 0x1E -> 0x000000FF.
  - LH 0x1E -> 0xFFFF80FF.
  - LHU 0x1C -> 0x00007F01.
- Word 3 = 0x11223344. SB 0x0E data 0xAA -> WRITE cycle writes 0x11AA3344 to index 3, exactly one mem_we pulse. SH 0x0C data 0xBEEF -> 0x11AABEEF.
- Misaligned and out-of-range: SW 0x02, LH 0x05, LW 0x00040000 (ADDR_W=16) -> resp_err 1, resp_data 0, mem_we never high, memory unchanged.
- Back-pressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid, resp_data and resp_err stay stable, req_ready 0, a new req_valid is ignored. Release -> next request accepted the following cycle.
- Assert rst_n=0 during ACCESS of an SB -> outputs reset immediately, target word unchanged, req_ready 1. A following LW returns the original value.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the CPU memory stage and a word-addressed data memory.
// Handles alignment/range errors, sub-word read-modify-write and load extension.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | memory read (loads, SH/SB) or word write (SW)
// WRITE  | commit merged word for SH/SB
// ERR    | flag error, no memory access
// RESP   | response held until resp_ready
module load_store_unit #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, ACCESS, WRITE, ERR, RESP} state_t;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  state_t              state, state_nxt;
  logic [2:0]          op_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         merge_q;

  logic                accept;
  logic                req_err;
  logic                is_load;
  logic                is_sub_store;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;
  logic [31:0]         load_val;
  logic [31:0]         merge_val;

  assign accept       = req_valid && req_ready;
  assign is_load      = (op_q <= OP_LBU);
  assign is_sub_store = (op_q == OP_SH) || (op_q == OP_SB);

  always_comb begin
    req_err = 1'b0;
    case (req_op)
      OP_LW, OP_SW:          req_err = (req_addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH:  req_err = req_addr[0];
      default:               req_err = 1'b0;
    endcase
    // Any address bit above the memory's byte range makes the access illegal.
    if ((req_addr >> (ADDR_W + 2)) != 32'd0)
      req_err = 1'b1;
  end

  assign lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h = mem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_val = 32'd0;
    case (op_q)
      OP_LW:   load_val = mem_rdata;
      OP_LH:   load_val = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  load_val = {16'd0, lane_h};
      OP_LB:   load_val = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  load_val = {24'd0, lane_b};
      default: load_val = 32'd0;
    endcase
  end

  always_comb begin
    merge_val = mem_rdata;
    if (op_q == OP_SB)
      merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = wdata_q;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept)
          state_nxt = req_err ? ERR : ACCESS;
      end
      ACCESS: begin
        mem_we    = (op_q == OP_SW);
        state_nxt = is_sub_store ? WRITE : RESP;
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = merge_q;
        state_nxt = RESP;
      end
      ERR: state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_addr = addr_q[ADDR_W+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      merge_q   <= 32'd0;
      resp_data <= 32'd0;
      resp_err  <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr[ADDR_W+1:0];
        wdata_q <= req_wdata;
      end
      case (state)
        ACCESS: begin
          resp_data <= is_load ? load_val : 32'd0;
          if (is_sub_store)
            merge_q <= merge_val;
        end
        ERR: begin
          resp_err  <= 1'b1;
          resp_data <= 32'd0;
        end
        RESP: begin
          // Response fields return to zero once the consumer has taken them.
          if (resp_ready) begin
            resp_data <= 32'd0;
            resp_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
